// File: rtl/tag_slot_scheduler_if.sv
// Handshake bundle between the subcarrier/tag-request side and the tag slot scheduler.
// The master drives requests and subcarriers; the slave (scheduler) drives the tag lanes.
interface tag_slot_scheduler_if #(
    parameter int unsigned NUM_TAGS = 3
);
    logic                en;
    logic [NUM_TAGS-1:0] tag_req;
    logic [NUM_TAGS-1:0] rate_sel;
    logic                sub_40;
    logic                sub_80;
    logic [NUM_TAGS-1:0] tag_out;
    logic [NUM_TAGS-1:0] tag_en;
    logic [2:0]          slot_idx;
    logic                frame_start;
    logic                busy;

    modport master (
        output en, tag_req, rate_sel, sub_40, sub_80,
        input  tag_out, tag_en, slot_idx, frame_start, busy
    );

    modport slave (
        input  en, tag_req, rate_sel, sub_40, sub_80,
        output tag_out, tag_en, slot_idx, frame_start, busy
    );
endinterface

// File: rtl/tag_slot_scheduler.sv
// Round-robin time-division scheduler: grants one requesting tag per slot, separated by
// all-off guard intervals, and gates that tag's selected subcarrier onto its lane.
module tag_slot_scheduler #(
    parameter int unsigned NUM_TAGS    = 3,
    parameter int unsigned TICK_DIV    = 12000,
    parameter int unsigned SLOT_TICKS  = 50,
    parameter int unsigned GUARD_TICKS = 2
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    tag_slot_scheduler_if.slave bus
);
    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StSelect, StGuard, StActive} state_e;

    state_e              r_state;
    logic [PreW-1:0]     r_pre_cnt;
    logic [15:0]         r_tick_cnt;
    logic [2:0]          r_last;
    logic                r_first;
    logic [2:0]          r_slot_idx;
    logic [NUM_TAGS-1:0] r_tag_en;
    logic [NUM_TAGS-1:0] r_tag_out;
    logic                r_frame_start;
    logic                r_busy;

    logic                  w_tick;
    logic [2*NUM_TAGS-1:0] w_req2;
    logic [NUM_TAGS-1:0]   w_rot;
    logic [3:0]            w_off;
    logic                  w_found;
    logic [2:0]            w_grant;
    logic                  w_wrap;
    logic [2:0]            w_sel_idx;
    logic [NUM_TAGS-1:0]   w_lane;
    logic                  w_rate;
    logic                  w_sub;

    assign w_tick = (r_pre_cnt == PreW'(TICK_DIV - 1));

    always_comb begin
        // Rotate requests so bit 0 is last+1; the lowest set bit is the next grant.
        w_req2 = {bus.tag_req, bus.tag_req};
        w_rot  = NUM_TAGS'(w_req2 >> ({1'b0, r_last} + 4'd1));
        w_off  = 4'd0;
        for (int p = NUM_TAGS - 1; p >= 0; p--) begin
            if (w_rot[p]) begin
                w_off = 4'(p);
            end
        end
        w_found = |w_rot;
        w_grant = 3'(({1'b0, r_last} + 4'd1 + w_off) % 4'(NUM_TAGS));
        w_wrap  = (w_grant <= r_last);
        // With no guard, ACTIVE is entered straight from SELECT using the fresh grant.
        w_sel_idx = (r_state == StSelect) ? w_grant : r_slot_idx;
        w_lane    = '0;
        w_rate    = 1'b0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (3'(i) == w_sel_idx) begin
                w_lane[i] = 1'b1;
                w_rate    = bus.rate_sel[i];
            end
        end
        w_sub = w_rate ? bus.sub_80 : bus.sub_40;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_pre_cnt     <= '0;
            r_tick_cnt    <= '0;
            r_last        <= 3'(NUM_TAGS - 1);
            r_first       <= 1'b1;
            r_slot_idx    <= 3'(NUM_TAGS - 1);
            r_tag_en      <= '0;
            r_tag_out     <= '0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_pre_cnt     <= w_tick ? '0 : r_pre_cnt + 1'b1;
            r_frame_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_tag_en  <= '0;
                    r_tag_out <= '0;
                    r_first   <= 1'b1;
                    r_busy    <= 1'b0;
                    if (bus.en && (|bus.tag_req)) begin
                        r_state <= StSelect;
                        r_busy  <= 1'b1;
                    end
                end
                StSelect: begin
                    r_pre_cnt  <= '0;
                    r_tick_cnt <= '0;
                    if (!bus.en || !w_found) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_slot_idx    <= w_grant;
                        r_last        <= w_grant;
                        r_first       <= 1'b0;
                        r_frame_start <= r_first || w_wrap;
                        if (GUARD_TICKS == 0) begin
                            r_state   <= StActive;
                            r_tag_en  <= w_lane;
                            r_tag_out <= w_sub ? w_lane : '0;
                        end else begin
                            r_state <= StGuard;
                        end
                    end
                end
                StGuard: begin
                    if (!bus.en) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else if (w_tick && (r_tick_cnt == 16'(GUARD_TICKS - 1))) begin
                        r_state    <= StActive;
                        r_tick_cnt <= '0;
                        r_tag_en   <= w_lane;
                        r_tag_out  <= w_sub ? w_lane : '0;
                    end else if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 16'd1;
                    end
                end
                StActive: begin
                    if (!bus.en) begin
                        r_state   <= StIdle;
                        r_busy    <= 1'b0;
                        r_tag_en  <= '0;
                        r_tag_out <= '0;
                    end else if (w_tick && (r_tick_cnt == 16'(SLOT_TICKS - 1))) begin
                        r_state    <= StSelect;
                        r_tick_cnt <= '0;
                        r_tag_en   <= '0;
                        r_tag_out  <= '0;
                    end else begin
                        r_tag_out <= w_sub ? w_lane : '0;
                        if (w_tick) begin
                            r_tick_cnt <= r_tick_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.tag_en      = r_tag_en;
    assign bus.tag_out     = r_tag_out;
    assign bus.slot_idx    = r_slot_idx;
    assign bus.frame_start = r_frame_start;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_tag_slot_scheduler.sv
// Bench for tag_slot_scheduler: two instances (guard 1 tick and no guard) share stimulus and are
// compared every cycle against a segment-countdown model of the schedule.
module tb_tag_slot_scheduler;
    localparam int NT = 3;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int G0 = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [NT-1:0] tag_req;
    logic [NT-1:0] rate_sel;
    logic          sub_40;
    logic          sub_80;
    bit            rnd_sub;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: mode 0 idle, 1 select, 2 guard, 3 active; m_left = cycles left in the segment.
    int m_mode[2];
    int m_left[2];
    int m_last[2];
    int m_slot[2];
    bit m_first[2];
    int e_en[2];
    int e_out[2];
    int e_fs[2];
    int e_busy[2];

    tag_slot_scheduler_if #(.NUM_TAGS(NT)) bus0 ();
    tag_slot_scheduler_if #(.NUM_TAGS(NT)) bus1 ();

    assign bus0.en       = en;
    assign bus0.tag_req  = tag_req;
    assign bus0.rate_sel = rate_sel;
    assign bus0.sub_40   = sub_40;
    assign bus0.sub_80   = sub_80;
    assign bus1.en       = en;
    assign bus1.tag_req  = tag_req;
    assign bus1.rate_sel = rate_sel;
    assign bus1.sub_40   = sub_40;
    assign bus1.sub_80   = sub_80;

    tag_slot_scheduler #(
        .NUM_TAGS(NT), .TICK_DIV(TD), .SLOT_TICKS(ST), .GUARD_TICKS(G0)
    ) u_dut0 (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus0)
    );

    tag_slot_scheduler #(
        .NUM_TAGS(NT), .TICK_DIV(TD), .SLOT_TICKS(ST), .GUARD_TICKS(0)
    ) u_dut1 (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int d, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_step(input int d);
        int g, req, rate, grant, idx;
        bit found, sub;
        g    = (d == 0) ? G0 : 0;
        req  = int'(tag_req);
        rate = int'(rate_sel);
        e_fs[d] = 0;
        if (!rst_n) begin
            m_mode[d]  = 0;
            m_left[d]  = 0;
            m_last[d]  = NT - 1;
            m_slot[d]  = NT - 1;
            m_first[d] = 1;
        end else begin
            case (m_mode[d])
                0: if (en && req != 0) m_mode[d] = 1;
                1: begin
                    found = 0;
                    grant = 0;
                    for (int k = 1; k <= NT; k++) begin
                        idx = (m_last[d] + k) % NT;
                        if (!found && ((req >> idx) & 1) == 1) begin
                            found = 1;
                            grant = idx;
                        end
                    end
                    if (!en || !found) begin
                        m_mode[d] = 0;
                    end else begin
                        e_fs[d]    = (m_first[d] || grant <= m_last[d]) ? 1 : 0;
                        m_last[d]  = grant;
                        m_slot[d]  = grant;
                        m_first[d] = 0;
                        if (g == 0) begin
                            m_mode[d] = 3;
                            m_left[d] = ST * TD;
                        end else begin
                            m_mode[d] = 2;
                            m_left[d] = g * TD;
                        end
                    end
                end
                2: begin
                    if (!en) begin
                        m_mode[d] = 0;
                    end else begin
                        m_left[d]--;
                        if (m_left[d] == 0) begin
                            m_mode[d] = 3;
                            m_left[d] = ST * TD;
                        end
                    end
                end
                3: begin
                    if (!en) begin
                        m_mode[d] = 0;
                    end else begin
                        m_left[d]--;
                        if (m_left[d] == 0) m_mode[d] = 1;
                    end
                end
                default: m_mode[d] = 0;
            endcase
        end
        if (m_mode[d] == 0) m_first[d] = 1;
        e_busy[d] = (m_mode[d] != 0) ? 1 : 0;
        e_en[d]   = (m_mode[d] == 3) ? (1 << m_slot[d]) : 0;
        sub       = (((rate >> m_slot[d]) & 1) == 1) ? sub_80 : sub_40;
        e_out[d]  = (m_mode[d] == 3 && sub) ? e_en[d] : 0;
    endtask

    task automatic check_all(input int d);
        logic [NT-1:0] o_en, o_out;
        logic [2:0]    o_slot;
        logic          o_fs, o_busy;
        if (d == 0) begin
            o_en = bus0.tag_en; o_out = bus0.tag_out; o_slot = bus0.slot_idx;
            o_fs = bus0.frame_start; o_busy = bus0.busy;
        end else begin
            o_en = bus1.tag_en; o_out = bus1.tag_out; o_slot = bus1.slot_idx;
            o_fs = bus1.frame_start; o_busy = bus1.busy;
        end
        check("tag_en", d, 32'(o_en), e_en[d]);
        check("tag_out", d, 32'(o_out), e_out[d]);
        check("slot_idx", d, 32'(o_slot), m_slot[d]);
        check("frame_start", d, 32'(o_fs), e_fs[d]);
        check("busy", d, 32'(o_busy), e_busy[d]);
    endtask

    task automatic step();
        if (rnd_sub) sub_40 = 1'($urandom);
        else sub_40 = ~sub_40;
        sub_80 = 1'($urandom);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all(0);
        check_all(1);
    endtask

    // Advance until the guarded instance's model reaches the given mode/slot/remaining count.
    task automatic wait_for(input string tag, input int mode, input int slot, input int left);
        bit hit;
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (m_mode[0] == mode && (slot < 0 || m_slot[0] == slot) &&
                (left < 0 || m_left[0] == left)) hit = 1;
            else step();
        end
        if (!hit) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: wait expired", tag);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; tag_req = '0; rate_sel = '0;
        sub_40 = 1'b0; sub_80 = 1'b0; rnd_sub = 0;
        step();
        step();
        check("rst_slot", 0, 32'(bus0.slot_idx), NT - 1);
        check("rst_busy", 0, 32'(bus0.busy), 0);

        // Full rotation, then two-tag and single-tag patterns
        rst_n = 1'b1; en = 1'b1; tag_req = 3'b111;
        step();
        step();
        check("t1_first_grant", 0, 32'(bus0.slot_idx), 0);
        check("t1_first_fs", 0, 32'(bus0.frame_start), 1);
        repeat (70) step();
        tag_req = 3'b101;
        repeat (75) step();
        tag_req = 3'b010; rate_sel = 3'b010;
        repeat (60) step();

        // Abort in cycle 5 of tag 1's slot, then resume at tag 2
        tag_req = 3'b111; rate_sel = 3'b000;
        wait_for("t4_slot1", 3, 1, ST * TD - 4);
        en = 1'b0;
        step();
        check("t4_abort_en", 0, 32'(bus0.tag_en), 0);
        check("t4_abort_busy", 0, 32'(bus0.busy), 0);
        en = 1'b1;
        step();
        step();
        check("t4_resume_slot", 0, 32'(bus0.slot_idx), 2);
        check("t4_resume_fs", 0, 32'(bus0.frame_start), 1);

        // Request drops mid-slot and during guard
        wait_for("t5_slot0", 3, 0, ST * TD - 2);
        tag_req = 3'b110;
        wait_for("t5_guard", 2, -1, -1);
        check("t5_next_slot", 0, 32'(bus0.slot_idx), 1);
        tag_req = '0;
        wait_for("t5_idle", 0, -1, -1);
        check("t5_idle_busy", 0, 32'(bus0.busy), 0);

        // Reset pulse mid-slot
        tag_req = 3'b111;
        wait_for("t6_active", 3, -1, -1);
        rst_n = 1'b0;
        step();
        check("t6_rst_en", 0, 32'(bus0.tag_en), 0);
        check("t6_rst_slot", 0, 32'(bus0.slot_idx), NT - 1);
        rst_n = 1'b1;
        step();
        step();
        check("t6_first_grant", 0, 32'(bus0.slot_idx), 0);
        check("t6_first_fs", 0, 32'(bus0.frame_start), 1);

        // Randomized traffic
        rnd_sub = 1;
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) tag_req = NT'($urandom);
            rate_sel = NT'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
